// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings and helpers for the ID-stage hazard/stall unit.
// Holds the FSM state type, register/stall constants and the operand-match rule.
package hazard_stall_unit_pkg;

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} hazState_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam logic [1:0] LU_STALL       = 2'd1;
    localparam logic [1:0] BR_LD_EX_STALL = 2'd2;

    // An older destination feeds the ID instruction; $zero never creates a dependency.
    function automatic logic opMatch(input logic [4:0] dst, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic usesRt);
        return (dst != REG_ZERO) && ((dst == rs) || (usesRt && (dst == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Holds at all-ones instead of wrapping; clears asynchronously.
module hazard_stall_unit_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard unit: detects load-use and branch-operand hazards that
// forwarding cannot cover, sequences multi-cycle stalls and counts them.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [4:0]       ID_RegRs,
    input  logic [4:0]       ID_RegRt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             Branch_Taken,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_RegRd,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_RegRd,
    input  logic             Mem_Stall,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Pipe_Freeze,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] Flush_Count
);

    hazState_e  state, stateNext;
    logic [1:0] rem, remNext;
    logic [1:0] needN;
    logic       exMatch, memMatch;
    logic       stallInc, flushInc;

    assign exMatch  = opMatch(ID_EX_RegRd, ID_RegRs, ID_RegRt, ID_UsesRt);
    assign memMatch = opMatch(EX_MEM_RegRd, ID_RegRs, ID_RegRt, ID_UsesRt);

    // Worst-case bubbles needed before the ID instruction can proceed.
    always_comb begin
        needN = 2'd0;
        if (ID_EX_MemRead && exMatch)
            needN = LU_STALL;
        if (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && exMatch)
            needN = LU_STALL;
        if (ID_Branch && EX_MEM_MemRead && memMatch && (needN < LU_STALL))
            needN = LU_STALL;
        if (ID_Branch && ID_EX_MemRead && exMatch)
            needN = BR_LD_EX_STALL;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= 2'd0;
        end else begin
            state <= stateNext;
            rem   <= remNext;
        end
    end

    always_comb begin
        stateNext    = state;
        remNext      = rem;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Pipe_Freeze  = 1'b0;
        stallInc     = 1'b0;
        flushInc     = 1'b0;
        if (Mem_Stall) begin
            // Freeze everything; the stall sequence picks up where it left off.
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (state == STALL) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            stallInc     = 1'b1;
            remNext      = rem - 2'd1;
            if (rem == 2'd1)
                stateNext = RUN;
        end else if (needN != 2'd0) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            stallInc     = 1'b1;
            if (needN == BR_LD_EX_STALL) begin
                remNext   = needN - 2'd1;
                stateNext = STALL;
            end
        end else if (ID_Branch && Branch_Taken) begin
            IF_ID_Flush = 1'b1;
            flushInc    = 1'b1;
        end
    end

    hazard_stall_unit_sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk_i),
        .rstN  (rst_n),
        .inc   (stallInc),
        .count (Stall_Cycles)
    );

    hazard_stall_unit_sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clk   (clk_i),
        .rstN  (rst_n),
        .inc   (flushInc),
        .count (Flush_Count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios plus random traffic against
// a model that tracks "bubbles still owed" rather than FSM state.
module tb_hazard_stall_unit;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] ID_RegRs, ID_RegRt, ID_EX_RegRd, EX_MEM_RegRd;
    logic       ID_UsesRt, ID_Branch, Branch_Taken, ID_EX_MemRead, ID_EX_RegWrite;
    logic       EX_MEM_MemRead, Mem_Stall;
    logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze;
    logic [15:0] Stall_Cycles, Flush_Count;
    logic       sPC, sIfw, sFl, sBub, sFrz;
    logic [1:0] sStall, sFlush;
    logic [4:0] outs, sOuts;

    int nCmp = 0;
    int nErr = 0;

    // model state
    int mPend, mStall, mFlush, mStallSat, mFlushSat;
    logic [4:0] eOuts;
    logic eStallInc, eFlushInc;
    int eNextPend;

    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_FLUSH = 5'b11100;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_FRZ   = 5'b00001;

    always #5 clk_i = ~clk_i;

    assign outs  = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze};
    assign sOuts = {sPC, sIfw, sFl, sBub, sFrz};

    hazard_stall_unit dut (
        .clk_i(clk_i), .rst_n(rst_n), .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
        .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch), .Branch_Taken(Branch_Taken),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_RegRd(ID_EX_RegRd), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_RegRd(EX_MEM_RegRd), .Mem_Stall(Mem_Stall), .PC_Write(PC_Write),
        .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
        .Pipe_Freeze(Pipe_Freeze), .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
    );

    hazard_stall_unit #(.CNT_W(2)) dutSat (
        .clk_i(clk_i), .rst_n(rst_n), .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
        .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch), .Branch_Taken(Branch_Taken),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_RegRd(ID_EX_RegRd), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_RegRd(EX_MEM_RegRd), .Mem_Stall(Mem_Stall), .PC_Write(sPC),
        .IF_ID_Write(sIfw), .IF_ID_Flush(sFl), .ID_EX_Bubble(sBub),
        .Pipe_Freeze(sFrz), .Stall_Cycles(sStall), .Flush_Count(sFlush)
    );

    function automatic bit depends(input logic [4:0] r);
        return (r != 5'd0) && ((r == ID_RegRs) || (ID_UsesRt && (r == ID_RegRt)));
    endfunction

    function automatic int reqStalls();
        int n = 0;
        if (ID_EX_MemRead && depends(ID_EX_RegRd)) n = (n > 1) ? n : 1;
        if (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && depends(ID_EX_RegRd)) n = (n > 1) ? n : 1;
        if (ID_Branch && ID_EX_MemRead && depends(ID_EX_RegRd)) n = 2;
        if (ID_Branch && EX_MEM_MemRead && depends(EX_MEM_RegRd)) n = (n > 1) ? n : 1;
        return n;
    endfunction

    task automatic expOut();
        int n;
        eStallInc = 1'b0;
        eFlushInc = 1'b0;
        eNextPend = mPend;
        if (Mem_Stall) begin
            eOuts = O_FRZ;
        end else if (mPend > 0) begin
            eOuts = O_STALL; eStallInc = 1'b1; eNextPend = mPend - 1;
        end else begin
            n = reqStalls();
            if (n > 0) begin
                eOuts = O_STALL; eStallInc = 1'b1; eNextPend = n - 1;
            end else if (ID_Branch && Branch_Taken) begin
                eOuts = O_FLUSH; eFlushInc = 1'b1;
            end else begin
                eOuts = O_RUN;
            end
        end
    endtask

    task automatic modelReset();
        mPend = 0; mStall = 0; mFlush = 0; mStallSat = 0; mFlushSat = 0;
    endtask

    task automatic advance();
        expOut();
        @(posedge clk_i);
        if (rst_n) begin
            mPend = eNextPend;
            if (eStallInc) begin
                mStall    = (mStall < 65535) ? mStall + 1 : mStall;
                mStallSat = (mStallSat < 3) ? mStallSat + 1 : mStallSat;
            end
            if (eFlushInc) begin
                mFlush    = (mFlush < 65535) ? mFlush + 1 : mFlush;
                mFlushSat = (mFlushSat < 3) ? mFlushSat + 1 : mFlushSat;
            end
        end
        #1;
    endtask

    task automatic clearIn();
        ID_RegRs = 0; ID_RegRt = 0; ID_UsesRt = 0; ID_Branch = 0; Branch_Taken = 0;
        ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_RegRd = 0;
        EX_MEM_MemRead = 0; EX_MEM_RegRd = 0; Mem_Stall = 0;
    endtask

    task automatic doReset();
        clearIn();
        rst_n = 1'b0;
        modelReset();
        #3;
        @(negedge clk_i) rst_n = 1'b1;
        advance();
    endtask

    task automatic setBranchLoad();
        clearIn();
        ID_Branch = 1; ID_RegRt = 5; ID_UsesRt = 1; ID_RegRs = 1;
        ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_RegRd = 5;
    endtask

    task automatic test_reset();
        clearIn();
        rst_n = 1'b0;
        modelReset();
        #2;
        nCmp++;
        if (outs !== O_RUN) begin nErr++; $display("FAIL reset_outs: got %b want %b", outs, O_RUN); end
        nCmp++;
        if (Stall_Cycles !== 16'd0 || Flush_Count !== 16'd0) begin
            nErr++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", Stall_Cycles, Flush_Count);
        end
        @(negedge clk_i) rst_n = 1'b1;
        advance();
    endtask

    task automatic test_load_use();
        doReset();
        ID_RegRs = 2; ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_RegRd = 2;
        #1;
        nCmp++;
        if (outs !== O_STALL) begin nErr++; $display("FAIL lu_stall: got %b want %b", outs, O_STALL); end
        advance();
        ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_RegRd = 0;
        #1;
        nCmp++;
        if (outs !== O_RUN) begin nErr++; $display("FAIL lu_resume: got %b want %b", outs, O_RUN); end
        advance();
        nCmp++;
        if (Stall_Cycles !== 16'd1) begin nErr++; $display("FAIL lu_count: got %0d want 1", Stall_Cycles); end
    endtask

    task automatic test_branch_load();
        doReset();
        setBranchLoad();
        #1;
        nCmp++;
        if (outs !== O_STALL) begin nErr++; $display("FAIL brld_c1: got %b want %b", outs, O_STALL); end
        advance();
        clearIn();  // no hazard visible: the second bubble must come from the sequencer
        #1;
        nCmp++;
        if (outs !== O_STALL) begin nErr++; $display("FAIL brld_c2: got %b want %b", outs, O_STALL); end
        advance();
        #1;
        nCmp++;
        if (outs !== O_RUN) begin nErr++; $display("FAIL brld_run: got %b want %b", outs, O_RUN); end
        advance();
        nCmp++;
        if (Stall_Cycles !== 16'd2) begin nErr++; $display("FAIL brld_count: got %0d want 2", Stall_Cycles); end
    endtask

    task automatic test_zero_rtunused();
        doReset();
        ID_EX_MemRead = 1; ID_EX_RegRd = 0; ID_RegRs = 0; ID_Branch = 1;
        EX_MEM_MemRead = 1; EX_MEM_RegRd = 0;
        #1;
        nCmp++;
        if (outs !== O_RUN) begin nErr++; $display("FAIL zero_reg: got %b want %b", outs, O_RUN); end
        advance();
        clearIn();
        ID_EX_MemRead = 1; ID_EX_RegRd = 7; ID_RegRt = 7; ID_UsesRt = 0; ID_RegRs = 3;
        #1;
        nCmp++;
        if (outs !== O_RUN) begin nErr++; $display("FAIL rt_unused: got %b want %b", outs, O_RUN); end
        advance();
        nCmp++;
        if (Stall_Cycles !== 16'd0) begin nErr++; $display("FAIL zero_count: got %0d want 0", Stall_Cycles); end
    endtask

    task automatic test_taken_branch();
        doReset();
        ID_Branch = 1; Branch_Taken = 1; ID_RegRs = 4;
        #1;
        nCmp++;
        if (outs !== O_FLUSH) begin nErr++; $display("FAIL br_flush: got %b want %b", outs, O_FLUSH); end
        advance();
        ID_EX_RegWrite = 1; ID_EX_RegRd = 4;
        #1;
        nCmp++;
        if (outs !== O_STALL) begin nErr++; $display("FAIL br_hz_stall: got %b want %b", outs, O_STALL); end
        advance();
        ID_EX_RegWrite = 0; ID_EX_RegRd = 0;
        #1;
        nCmp++;
        if (outs !== O_FLUSH) begin nErr++; $display("FAIL br_hz_flush: got %b want %b", outs, O_FLUSH); end
        advance();
        nCmp++;
        if (Flush_Count !== 16'd2 || Stall_Cycles !== 16'd1) begin
            nErr++; $display("FAIL br_counts: got flush %0d stall %0d want 2 1", Flush_Count, Stall_Cycles);
        end
    endtask

    task automatic test_mem_stall();
        doReset();
        setBranchLoad();
        advance();
        clearIn();
        Mem_Stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nCmp++;
            if (outs !== O_FRZ) begin nErr++; $display("FAIL ms_freeze%0d: got %b want %b", i, outs, O_FRZ); end
            advance();
        end
        Mem_Stall = 0;
        #1;
        nCmp++;
        if (outs !== O_STALL) begin nErr++; $display("FAIL ms_resume: got %b want %b", outs, O_STALL); end
        advance();
        #1;
        nCmp++;
        if (outs !== O_RUN) begin nErr++; $display("FAIL ms_run: got %b want %b", outs, O_RUN); end
        advance();
        nCmp++;
        if (Stall_Cycles !== 16'd2) begin nErr++; $display("FAIL ms_count: got %0d want 2", Stall_Cycles); end
    endtask

    task automatic test_reset_mid_stall();
        doReset();
        setBranchLoad();
        advance();
        clearIn();
        #1;
        nCmp++;
        if (outs !== O_STALL) begin nErr++; $display("FAIL rms_pre: got %b want %b", outs, O_STALL); end
        rst_n = 1'b0;
        modelReset();
        #1;
        nCmp++;
        if (outs !== O_RUN || Stall_Cycles !== 16'd0) begin
            nErr++; $display("FAIL rms_abort: got %b cnt %0d want %b cnt 0", outs, Stall_Cycles, O_RUN);
        end
        @(negedge clk_i) rst_n = 1'b1;
        advance();
    endtask

    task automatic test_saturation();
        doReset();
        ID_RegRs = 6; ID_EX_MemRead = 1; ID_EX_RegRd = 6;
        for (int i = 0; i < 5; i++) advance();
        nCmp++;
        if (sStall !== 2'd3) begin nErr++; $display("FAIL sat_narrow: got %0d want 3", sStall); end
        nCmp++;
        if (Stall_Cycles !== 16'd5) begin nErr++; $display("FAIL sat_wide: got %0d want 5", Stall_Cycles); end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 400; i++) begin
            ID_RegRs       = 5'($urandom_range(0, 3));
            ID_RegRt       = 5'($urandom_range(0, 3));
            ID_UsesRt      = 1'($urandom);
            ID_Branch      = 1'($urandom);
            Branch_Taken   = 1'($urandom);
            ID_EX_MemRead  = 1'($urandom);
            ID_EX_RegWrite = 1'($urandom);
            ID_EX_RegRd    = 5'($urandom_range(0, 3));
            EX_MEM_MemRead = 1'($urandom);
            EX_MEM_RegRd   = 5'($urandom_range(0, 3));
            Mem_Stall      = ($urandom_range(0, 4) == 0);
            #1;
            expOut();
            nCmp++;
            if (outs !== eOuts || sOuts !== eOuts) begin
                nErr++; $display("FAIL rnd_outs[%0d]: got %b/%b want %b", i, outs, sOuts, eOuts);
            end
            advance();
            nCmp++;
            if (Stall_Cycles !== 16'(mStall) || Flush_Count !== 16'(mFlush) ||
                sStall !== 2'(mStallSat) || sFlush !== 2'(mFlushSat)) begin
                nErr++;
                $display("FAIL rnd_cnt[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                         Stall_Cycles, Flush_Count, sStall, sFlush, mStall, mFlush, mStallSat, mFlushSat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_zero_rtunused();
        test_taken_branch();
        test_mem_stall();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
